// File: rtl/hpdl1414_uart_array_pkg.sv
// Shared constants, writer state encoding and address mapping for the
// HPDL-1414 UART text controller.
package hpdl_pkg;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] PRINT_LO   = 8'h20;
  localparam logic [7:0] PRINT_HI   = 8'h5F;
  localparam logic [7:0] LOWER_LO   = 8'h61;
  localparam logic [7:0] LOWER_HI   = 8'h7A;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} wr_state_t;

  // Position 0 of each display is its leftmost digit, which the part addresses as 3.
  function automatic logic [1:0] pos_to_addr(input logic [1:0] pos_lo);
    return 2'd3 - pos_lo;
  endfunction

endpackage

// File: rtl/hpdl1414_uart_array_uart_rx.sv
// 8N1 UART receiver with a two-flop synchroniser; emits a one-cycle valid
// strobe per good byte and a one-cycle frame_err pulse on a bad stop bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      bit_idx, bit_d;
  logic [7:0]      shreg, shreg_d, data_d;
  logic            valid_d, err_d;
  logic            rx_s1, rx_s2, rx_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_s3     <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= rx;
      rx_s2     <= rx_s1;
      rx_s3     <= rx_s2;
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_d;
      valid     <= valid_d;
      frame_err <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_d;
    data  <= data_d;
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    shreg_d = shreg;
    data_d  = data;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_d = '0;
        if (rx_s3 && !rx_s2) begin
          state_d = RX_START;
          cnt_d   = HALF_CNT;
        end
      end
      RX_START: begin
        if (cnt == '0) begin
          if (rx_s2) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = FULL_CNT;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt == '0) begin
          shreg_d = {rx_s2, shreg[7:1]};
          cnt_d   = FULL_CNT;
          if (bit_idx == 3'd7) state_d = RX_STOP;
          else                 bit_d   = bit_idx + 3'd1;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt == '0) begin
          state_d = RX_IDLE;
          if (rx_s2) begin
            valid_d = 1'b1;
            data_d  = shreg;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/hpdl1414_uart_array.sv
// UART-fed text buffer for a chain of HPDL-1414 displays, with a write
// sequencer that copies dirty positions out using programmable bus timing.
module hpdl1414_uart_array
  import hpdl_pkg::*;
#(
  parameter int NUM_DISP     = 4,
  parameter int CLKS_PER_BIT = 104,
  parameter int WR_SETUP     = 2,
  parameter int WR_PULSE     = 4,
  parameter int WR_HOLD      = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                uart_rx,
  input  logic                scroll_en,
  output logic [6:0]          hpdl_d,
  output logic [1:0]          hpdl_a,
  output logic [NUM_DISP-1:0] hpdl_wr_n,
  output logic                busy,
  output logic                rx_err
);

  localparam int N    = 4 * NUM_DISP;
  localparam int PW   = $clog2(N);
  localparam int TMAX = (WR_SETUP > WR_PULSE) ? ((WR_SETUP > WR_HOLD) ? WR_SETUP : WR_HOLD)
                                              : ((WR_PULSE > WR_HOLD) ? WR_PULSE : WR_HOLD);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  logic [7:0] rx_data;
  logic       rx_valid;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (uart_rx),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_err)
  );

  logic [6:0]    pos [N];
  logic [N-1:0]  dirty, set_dirty, clr_vec;
  logic [PW-1:0] cursor;
  logic          line_full;
  logic [6:0]    ch;
  logic          is_store, is_cr, is_ff, do_shift;

  // Byte decode
  always_comb begin
    ch       = rx_data[6:0];
    is_store = 1'b0;
    is_cr    = 1'b0;
    is_ff    = 1'b0;
    if (rx_valid) begin
      if (rx_data >= PRINT_LO && rx_data <= PRINT_HI) begin
        is_store = 1'b1;
      end else if (rx_data >= LOWER_LO && rx_data <= LOWER_HI) begin
        is_store = 1'b1;
        ch       = rx_data[6:0] - 7'h20;
      end else if (rx_data == CHAR_CR) begin
        is_cr = 1'b1;
      end else if (rx_data == CHAR_FF) begin
        is_ff = 1'b1;
      end
    end
    // line_full marks that the last cell was stored in scroll mode; only then does a store shift
    do_shift = is_store && line_full && scroll_en;
    for (int i = 0; i < N; i++)
      set_dirty[i] = is_ff || do_shift || (is_store && cursor == PW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) pos[i] <= CHAR_SPACE[6:0];
      cursor    <= '0;
      line_full <= 1'b0;
    end else if (is_ff) begin
      for (int i = 0; i < N; i++) pos[i] <= CHAR_SPACE[6:0];
      cursor    <= '0;
      line_full <= 1'b0;
    end else if (is_cr) begin
      cursor    <= '0;
      line_full <= 1'b0;
    end else if (do_shift) begin
      for (int i = 0; i < N - 1; i++) pos[i] <= pos[i+1];
      pos[N-1] <= ch;
    end else if (is_store) begin
      pos[cursor] <= ch;
      if (cursor == PW'(N - 1)) begin
        if (scroll_en) begin
          line_full <= 1'b1;
        end else begin
          cursor    <= '0;
          line_full <= 1'b0;
        end
      end else begin
        cursor    <= cursor + PW'(1);
        line_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dirty <= '1;
    else        dirty <= set_dirty | (dirty & ~clr_vec);
  end

  wr_state_t             state, state_d;
  logic [TW-1:0]         tcnt, tcnt_d;
  logic [PW-1:0]         sel, sel_d, pick;
  logic                  pick_found, rewrite, rewrite_d, latch, seq_clr;
  logic [NUM_DISP-1:0]   wr_n_d;
  int                    idx;

  // Round-robin scan starting just after the last served position
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    idx        = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(sel) + k) % N;
      if (!pick_found && dirty[idx]) begin
        pick_found = 1'b1;
        pick       = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state;
    tcnt_d    = tcnt;
    sel_d     = sel;
    rewrite_d = rewrite;
    latch     = 1'b0;
    seq_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_d   = SETUP;
          tcnt_d    = TW'(WR_SETUP - 1);
          sel_d     = pick;
          rewrite_d = set_dirty[pick];
          latch     = 1'b1;
        end
      end
      SETUP: begin
        rewrite_d = rewrite | set_dirty[sel];
        if (tcnt == '0) begin
          state_d = STROBE;
          tcnt_d  = TW'(WR_PULSE - 1);
        end else begin
          tcnt_d = tcnt - TW'(1);
        end
      end
      STROBE: begin
        rewrite_d = rewrite | set_dirty[sel];
        if (tcnt == '0) begin
          state_d = HOLD;
          tcnt_d  = TW'(WR_HOLD - 1);
        end else begin
          tcnt_d = tcnt - TW'(1);
        end
      end
      HOLD: begin
        rewrite_d = rewrite | set_dirty[sel];
        if (tcnt == '0) begin
          state_d   = IDLE;
          tcnt_d    = '0;
          seq_clr   = !rewrite;
          rewrite_d = 1'b0;
        end else begin
          tcnt_d = tcnt - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    clr_vec = '0;
    if (seq_clr) clr_vec[sel] = 1'b1;
    wr_n_d = '1;
    if (state_d == STROBE) wr_n_d[int'(sel_d) / 4] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      sel       <= PW'(N - 1);
      rewrite   <= 1'b0;
      hpdl_wr_n <= '1;
      hpdl_d    <= '0;
      hpdl_a    <= '0;
    end else begin
      state     <= state_d;
      tcnt      <= tcnt_d;
      sel       <= sel_d;
      rewrite   <= rewrite_d;
      hpdl_wr_n <= wr_n_d;
      if (latch) begin
        hpdl_d <= pos[pick];
        hpdl_a <= pos_to_addr(pick[1:0]);
      end
    end
  end

  assign busy = (|dirty) || (state != IDLE);

endmodule

// File: tb/tb_hpdl1414_uart_array.sv
// Randomised scoreboard bench: a line-level text model predicts every display
// write; a monitor checks each strobe's target, data and timing as it happens.
module tb_hpdl1414_uart_array;

  localparam int NUM_DISP = 2;
  localparam int CPB      = 8;
  localparam int WS       = 2;
  localparam int WP       = 4;
  localparam int WH       = 2;
  localparam int N        = 4 * NUM_DISP;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                uart_rx = 1'b1;
  logic                scroll_en = 1'b0;
  logic [6:0]          hpdl_d;
  logic [1:0]          hpdl_a;
  logic [NUM_DISP-1:0] hpdl_wr_n;
  logic                busy;
  logic                rx_err;

  always #5 clk = ~clk;

  hpdl1414_uart_array #(
    .NUM_DISP(NUM_DISP), .CLKS_PER_BIT(CPB), .WR_SETUP(WS), .WR_PULSE(WP), .WR_HOLD(WH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .scroll_en(scroll_en),
    .hpdl_d(hpdl_d), .hpdl_a(hpdl_a), .hpdl_wr_n(hpdl_wr_n), .busy(busy), .rx_err(rx_err)
  );

  typedef struct {int disp; int addr; int ch;} strobe_t;
  strobe_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Text model: what the line of characters should look like, and which writes follow
  int m_buf [N];
  int m_cur;
  bit m_full;
  int m_last;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_buf[i] = 32;
    m_cur  = 0;
    m_full = 0;
    m_last = N - 1;
  endtask

  task automatic push_pos(input int p);
    strobe_t s;
    s.disp = p / 4;
    s.addr = 3 - (p % 4);
    s.ch   = m_buf[p];
    exp_q.push_back(s);
    m_last = p;
  endtask

  task automatic push_all();
    int start;
    start = m_last;
    for (int k = 1; k <= N; k++) push_pos((start + k) % N);
  endtask

  task automatic model_byte(input int b);
    int c;
    if ((b >= 32 && b <= 95) || (b >= 97 && b <= 122)) begin
      c = (b >= 97) ? b - 32 : b;
      if (m_full && scroll_en) begin
        for (int i = 0; i < N - 1; i++) m_buf[i] = m_buf[i+1];
        m_buf[N-1] = c;
        push_all();
      end else begin
        m_buf[m_cur] = c;
        push_pos(m_cur);
        if (m_cur == N - 1) begin
          if (scroll_en) m_full = 1;
          else begin m_cur = 0; m_full = 0; end
        end else begin
          m_cur++;
          m_full = 0;
        end
      end
    end else if (b == 13) begin
      m_cur  = 0;
      m_full = 0;
    end else if (b == 12) begin
      for (int i = 0; i < N; i++) m_buf[i] = 32;
      m_cur  = 0;
      m_full = 0;
      push_all();
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int b, input bit stop);
    logic [7:0] bv;
    bv = 8'(b);
    uart_rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = bv[i];
      wait_clks(CPB);
    end
    uart_rx = stop;
  endtask

  task automatic send_byte(input int b, input bit stop);
    send_frame(b, stop);
    wait_clks(CPB);
    uart_rx = 1'b1;
    wait_clks(CPB);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    wait_clks(4);
    while (busy !== 1'b0 && t < 3000) begin
      wait_clks(1);
      t++;
    end
    check("busy_idle", int'(busy), 0);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_byte(input int b);
    model_byte(b);
    send_byte(b, 1'b1);
    wait_idle();
  endtask

  function automatic int disp_of(input logic [NUM_DISP-1:0] w);
    for (int i = 0; i < NUM_DISP; i++) if (!w[i]) return i;
    return -1;
  endfunction

  // Monitor
  bit         in_strobe = 0;
  bit         abort_strobe = 0;
  int         mon_len = 0;
  int         s_d, s_a;
  logic [6:0] prev_d;
  logic [1:0] prev_a;
  int         err_pulses = 0;
  int         err_len = 0;

  always @(negedge clk) begin
    strobe_t e;
    if (!in_strobe && hpdl_wr_n != '1) begin
      in_strobe = 1;
      mon_len   = 1;
      check("one_wr_low", $countones(~hpdl_wr_n), 1);
      check("setup_d", int'(hpdl_d), int'(prev_d));
      check("setup_a", int'(hpdl_a), int'(prev_a));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: disp %0d a %0d d 0x%0h, expected none", disp_of(hpdl_wr_n), hpdl_a, hpdl_d);
      end else begin
        e = exp_q.pop_front();
        check("strobe_disp", disp_of(hpdl_wr_n), e.disp);
        check("strobe_a", int'(hpdl_a), e.addr);
        check("strobe_d", int'(hpdl_d), e.ch);
      end
      s_d = int'(hpdl_d);
      s_a = int'(hpdl_a);
    end else if (in_strobe) begin
      if (hpdl_wr_n != '1) begin
        mon_len++;
        check("d_stable", int'(hpdl_d), s_d);
        check("a_stable", int'(hpdl_a), s_a);
        check("one_wr_low", $countones(~hpdl_wr_n), 1);
      end else begin
        in_strobe = 0;
        if (!abort_strobe) check("pulse_width", mon_len, WP);
        abort_strobe = 0;
      end
    end
    prev_d = hpdl_d;
    prev_a = hpdl_a;
    if (rx_err === 1'b1) begin
      err_len++;
    end else if (err_len > 0) begin
      err_pulses++;
      check("rx_err_width", err_len, 1);
      err_len = 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    int e0, b, r;
    string s;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    check("rst_wr_n", int'(hpdl_wr_n), (1 << NUM_DISP) - 1);
    check("rst_d", int'(hpdl_d), 0);
    check("rst_a", int'(hpdl_a), 0);
    check("rst_rx_err", int'(rx_err), 0);
    check("rst_busy", int'(busy), 1);
    wait_clks(3);
    push_all();
    rst_n = 1'b1;
    wait_idle();

    s = "AB";
    for (int i = 0; i < s.len(); i++) do_byte(int'(s[i]));
    do_byte(8'h61);
    do_byte(8'h7F);
    do_byte(8'h43);

    for (int m = 0; m < 2; m++) begin
      scroll_en = (m == 0);
      do_byte(12);
      for (int i = 0; i < N; i++) do_byte($urandom_range(33, 90));
      do_byte(8'h5A);
      do_byte(8'h79);
    end

    e0 = err_pulses;
    send_byte($urandom_range(65, 90), 1'b0);
    wait_idle();
    wait_clks(2);
    check("rx_err_pulses", err_pulses - e0, 1);
    do_byte(12);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 15) == 0) scroll_en = ~scroll_en;
      r = $urandom_range(0, 19);
      b = (r == 0) ? 13 : (r == 1) ? 12 : $urandom_range(0, 255);
      do_byte(b);
    end

    model_byte(8'h51);
    send_frame(8'h51, 1'b1);
    r = 0;
    while (hpdl_wr_n == '1 && r < 200) begin
      wait_clks(1);
      r++;
    end
    check("strobe_before_reset", int'(hpdl_wr_n != '1), 1);
    wait_clks(1);
    abort_strobe = 1;
    rst_n = 1'b0;
    #1;
    check("async_rst_wr_n", int'(hpdl_wr_n), (1 << NUM_DISP) - 1);
    check("async_rst_d", int'(hpdl_d), 0);
    check("async_rst_a", int'(hpdl_a), 0);
    check("async_rst_busy", int'(busy), 1);
    uart_rx = 1'b1;
    exp_q.delete();
    model_reset();
    push_all();
    wait_clks(2);
    rst_n = 1'b1;
    wait_idle();
    do_byte(8'h4F);
    do_byte(8'h6B);

    check("rx_err_total", err_pulses, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
